// File: rtl/addsub_pkg.sv
// Shared types and helpers for the bit-serial add/subtract datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package addsub_pkg;

    // Controller states of the serial adder.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit-counter width for a given operand width (CNT_W = clog2(WIDTH)).
    // The counter only has to reach WIDTH-1.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with the carry/borrow held in a single flop between bits.
// Latency: sum bit s is combinational; carry_q updates on the clock edge.
// Backpressure: none; the carry advances only when en is high.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset (carry cleared)
//   load, init : synchronous preload of the carry flop (init = sub for a-b)
//   en         : advance carry by one bit position
//   a, b       : current operand bits
//   s          : sum bit for the current position
//   carry_q    : carry into the current bit position
module serial_fa_cell (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic init,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s,
    output logic carry_q
);

    assign s = a ^ b ^ carry_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else if (load) begin
            carry_q <= init;
        end else if (en) begin
            carry_q <= (a & b) | (a & carry_q) | (b & carry_q);
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement a+b / a-b, one bit per clock, LSB first.
// Latency: WIDTH edges from accepting edge to done; one op per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
//
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   start, sub    : request strobe and op select (0 = a+b, 1 = a-b), sampled in IDLE
//   a, b          : operands, sampled with start
//   busy          : high while bits are being processed
//   done          : one-cycle pulse once sum/cout/ovf hold the new result
//   sum, cout, ovf: result, carry out (sub: 1 = no borrow), signed overflow
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             shift_en;
    logic             last;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             carry_q;
    logic             carry_out;

    serial_fa_cell u_fa (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .init    (sub),
        .en      (shift_en),
        .a       (op_a[0]),
        .b       (op_b[0]),
        .s       (s),
        .carry_q (carry_q)
    );

    // Carry leaving the current bit; on the MSB edge this is the final cout,
    // while carry_q is still the carry into the MSB.
    assign carry_out = (op_a[0] & op_b[0]) | (op_a[0] & carry_q) | (op_b[0] & carry_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a <= '0;
            op_b <= '0;
            acc  <= '0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            op_a <= a;
            // Subtraction is a + ~b + 1; the +1 comes from the carry preload.
            op_b <= sub ? ~b : b;
            acc  <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            op_a <= op_a >> 1;
            op_b <= op_b >> 1;
            // Bits enter at the MSB so after WIDTH shifts bit 0 sits at position 0.
            acc  <= {s, acc[WIDTH-1:1]};
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
                sum  <= {s, acc[WIDTH-1:1]};
                cout <= carry_out;
                ovf  <= carry_q ^ carry_out;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed corners plus randomized ops.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;
    logic         last_ovf  = 1'b0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                         output logic [W-1:0] r, output logic c, output logic v);
        int ux;
        int uy;
        int sx;
        int sy;
        int ur;
        int sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!op) begin
            ur = ux + uy;
            sr = sx + sy;
            c  = (ur >= (1 << W));
        end else begin
            ur = ux - uy;
            sr = sx - sy;
            c  = (ux >= uy);
        end
        r = W'(ur);
        v = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    endtask

    // Runs one operation from an idle DUT and checks timing and result.
    // With disturb set, start is pulsed with fresh operands throughout SHIFT and DONE.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                         input bit disturb, input string tag);
        logic [W-1:0] es;
        logic         ec;
        logic         ev;
        model(x, y, op, es, ec, ev);

        @(negedge clk);
        a = x; b = y; sub = op; start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", tag, busy, done);
        end

        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (disturb) begin
                start = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
                sub = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (k < W) begin
                if (busy !== 1'b1 || done !== 1'b0 || sum !== last_sum ||
                    cout !== last_cout || ovf !== last_ovf) begin
                    errors++;
                    $display("FAIL %s shift edge %0d: busy=%b done=%b sum=%h cout=%b ovf=%b required busy=1 done=0 sum=%h cout=%b ovf=%b",
                             tag, k, busy, done, sum, cout, ovf, last_sum, last_cout, last_ovf);
                end
            end else begin
                if (busy !== 1'b0 || done !== 1'b1 || sum !== es || cout !== ec || ovf !== ev) begin
                    errors++;
                    $display("FAIL %s result: busy=%b done=%b sum=%h cout=%b ovf=%b required busy=0 done=1 sum=%h cout=%b ovf=%b",
                             tag, busy, done, sum, cout, ovf, es, ec, ev);
                end
            end
        end

        // DONE cycle: start (if disturbing) is still high and must be ignored.
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== es || cout !== ec || ovf !== ev) begin
            errors++;
            $display("FAIL %s after done: busy=%b done=%b sum=%h cout=%b ovf=%b required busy=0 done=0 sum=%h cout=%b ovf=%b",
                     tag, busy, done, sum, cout, ovf, es, ec, ev);
        end
        start = 1'b0;
        last_sum  = es;
        last_cout = ec;
        last_ovf  = ev;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b ovf=%b required all zero",
                     busy, done, sum, cout, ovf);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        do_op(8'h35, 8'h12, 1'b0, 1'b0, "add_35_12");
    endtask

    task automatic test_sub_borrow();
        do_op(8'h12, 8'h35, 1'b1, 1'b0, "sub_12_35");
    endtask

    task automatic test_add_overflow();
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, "add_7f_01");
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    endtask

    task automatic test_sub_overflow();
        do_op(8'h80, 8'h01, 1'b1, 1'b0, "sub_80_01");
    endtask

    task automatic test_ignore_start();
        do_op(8'hA5, 8'h3C, 1'b1, 1'b1, "ignore_start_sub");
        do_op(8'h44, 8'hC9, 1'b0, 1'b1, "ignore_start_add");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, "back_to_back");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        do_op(8'h35, 8'h12, 1'b0, 1'b0, "pre_reset");
        @(negedge clk);
        a = 8'h7F; b = 8'h01; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b ovf=%b required all zero",
                     busy, done, sum, cout, ovf);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0 || sum !== '0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_mid_quiet: activity after reset, last busy=%b done=%b sum=%h required 0 0 00",
                     busy, done, sum);
        end
        last_sum  = '0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
        do_op(8'h5A, 8'h27, 1'b1, 1'b0, "after_reset");
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_borrow();
        test_add_overflow();
        test_sub_overflow();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
